mpadd_seq: RTL and testbench

MPADD_SEQ -- requirements
Module: mpadd_seq

---
 rtl/mpadd_pkg.sv | 23 ++
 rtl/cla16_add.sv | 78 +++++++
 rtl/mpadd_seq.sv | 165 ++++++++++++++++
 tb/tb_mpadd_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpadd_pkg.sv
// -----------------------------------------------------------------------------
// mpadd_pkg
// Shared definitions for the sequential multi-precision adder (mpadd_seq) and
// its time-shared chunk adder (cla16_add).
//   CHUNK_W     : width of one adder chunk (16 bits)
//   IDX_W       : width of the chunk index (covers up to 8 chunks)
//   state_t     : controller states IDLE / RUN / DONE
//   chunk_idx_t : chunk index type used to walk the operands
// -----------------------------------------------------------------------------
package mpadd_pkg;

    localparam int CHUNK_W = 16;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0] chunk_idx_t;

endpackage

// File: rtl/cla16_add.sv
// -----------------------------------------------------------------------------
// cla16_add
// Combinational 16-bit carry-lookahead adder built from four 4-bit lookahead
// groups, with a second lookahead level across the group generate/propagate
// terms.
// Ports:
//   x[15:0], y[15:0] : addends
//   c0               : carry in
//   s[15:0]          : sum
//   c16              : carry out of bit 15
// -----------------------------------------------------------------------------
module cla16_add (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        c0,
    output logic [15:0] s,
    output logic        c16
);

    // Group generate/propagate of one 4-bit slice, returned as {G, P}.
    function automatic logic [1:0] grp_gp(input logic [3:0] gx, input logic [3:0] gy);
        logic [3:0] g;
        logic [3:0] p;
        logic       gg;
        logic       pp;
        g  = gx & gy;
        p  = gx ^ gy;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp};
    endfunction

    // Sum of one 4-bit slice given its carry in; internal carries are fully
    // expanded so each bit carry depends only on g/p terms and the slice carry in.
    function automatic logic [3:0] grp_sum(input logic [3:0] gx, input logic [3:0] gy,
                                           input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        g  = gx & gy;
        p  = gx ^ gy;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return p ^ {c3, c2, c1, ci};
    endfunction

    logic [1:0] gp0_s;
    logic [1:0] gp1_s;
    logic [1:0] gp2_s;
    logic [1:0] gp3_s;
    logic       gc1_s;
    logic       gc2_s;
    logic       gc3_s;

    assign gp0_s = grp_gp(x[3:0],   y[3:0]);
    assign gp1_s = grp_gp(x[7:4],   y[7:4]);
    assign gp2_s = grp_gp(x[11:8],  y[11:8]);
    assign gp3_s = grp_gp(x[15:12], y[15:12]);

    // Second-level lookahead: carries into groups 1..3 and out of group 3,
    // written flat so no group waits on the previous group's carry.
    assign gc1_s = gp0_s[1] | (gp0_s[0] & c0);
    assign gc2_s = gp1_s[1] | (gp1_s[0] & gp0_s[1]) | (gp1_s[0] & gp0_s[0] & c0);
    assign gc3_s = gp2_s[1] | (gp2_s[0] & gp1_s[1]) | (gp2_s[0] & gp1_s[0] & gp0_s[1])
                 | (gp2_s[0] & gp1_s[0] & gp0_s[0] & c0);
    assign c16   = gp3_s[1] | (gp3_s[0] & gp2_s[1]) | (gp3_s[0] & gp2_s[0] & gp1_s[1])
                 | (gp3_s[0] & gp2_s[0] & gp1_s[0] & gp0_s[1])
                 | (gp3_s[0] & gp2_s[0] & gp1_s[0] & gp0_s[0] & c0);

    assign s = {grp_sum(x[15:12], y[15:12], gc3_s),
                grp_sum(x[11:8],  y[11:8],  gc2_s),
                grp_sum(x[7:4],   y[7:4],   gc1_s),
                grp_sum(x[3:0],   y[3:0],   c0)};

endmodule

// File: rtl/mpadd_seq.sv
// -----------------------------------------------------------------------------
// mpadd_seq
// Sequential multi-precision adder. An operand set is captured on a valid/ready
// handshake, then added one 16-bit chunk per cycle through a single shared
// cla16_add instance, least significant chunk first. The result is held with
// out_valid until the consumer accepts it.
//
// Optional feature macro: MPADD_OVF_EN -- adds the signed-overflow output ovf.
//
// Parameters:
//   WORDS      : number of 16-bit chunks per operand (legal 2..8)
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : operand set offered
//   in_ready   : block can accept an operand set (IDLE only)
//   a, b       : operands, 16*WORDS bits
//   cin        : carry into chunk 0
//   out_valid  : result held and valid
//   out_ready  : consumer takes the result
//   sum        : a + b + cin modulo 2^(16*WORDS)
//   cout       : carry out of the top chunk
//   ovf        : signed overflow (MPADD_OVF_EN only)
// -----------------------------------------------------------------------------
module mpadd_seq
    import mpadd_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*WORDS-1:0]    a,
    input  logic [16*WORDS-1:0]    b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*WORDS-1:0]    sum,
    output logic                   cout
`ifdef MPADD_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int W = CHUNK_W * WORDS;

    state_t             state_r;
    chunk_idx_t         k_r;
    logic               carry_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic               cin_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               in_ready_r;
    logic               out_valid_r;
`ifdef MPADD_OVF_EN
    logic               ovf_r;
`endif

    logic [CHUNK_W-1:0] x_s;
    logic [CHUNK_W-1:0] y_s;
    logic               c0_s;
    logic [CHUNK_W-1:0] chunk_sum_s;
    logic               chunk_cout_s;
    logic               last_s;

    // Operand chunk selection and carry-in mux for the shared chunk adder.
    always_comb begin
        x_s    = a_r[int'(k_r)*CHUNK_W +: CHUNK_W];
        y_s    = b_r[int'(k_r)*CHUNK_W +: CHUNK_W];
        last_s = (k_r == chunk_idx_t'(WORDS-1));
        if (k_r == chunk_idx_t'(0)) begin
            c0_s = cin_r;
        end else begin
            c0_s = carry_r;
        end
    end

    cla16_add u_cla (
        .x   (x_s),
        .y   (y_s),
        .c0  (c0_s),
        .s   (chunk_sum_s),
        .c16 (chunk_cout_s)
    );

    // Controller: handshake, chunk sequencing and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= chunk_idx_t'(0);
            carry_r     <= 1'b0;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            cin_r       <= 1'b0;
            sum_r       <= {W{1'b0}};
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef MPADD_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        cin_r      <= cin;
                        k_r        <= chunk_idx_t'(0);
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    sum_r[int'(k_r)*CHUNK_W +: CHUNK_W] <= chunk_sum_s;
                    carry_r <= chunk_cout_s;
                    if (last_s) begin
                        // Index is parked at 0 so it never wraps past the
                        // top chunk for the 8-chunk configuration.
                        k_r         <= chunk_idx_t'(0);
                        cout_r      <= chunk_cout_s;
`ifdef MPADD_OVF_EN
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_r       <= (a_r[W-1] == b_r[W-1]) && (chunk_sum_s[CHUNK_W-1] != a_r[W-1]);
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        k_r <= k_r + chunk_idx_t'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    k_r         <= chunk_idx_t'(0);
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef MPADD_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_mpadd_seq.sv
// -----------------------------------------------------------------------------
// tb_mpadd_seq
// Directed bench for mpadd_seq with WORDS=4. Expected results are computed by
// the bench at accept time, queued, and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mpadd_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MPADD_OVF_EN
    logic         ovf;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mpadd_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef MPADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand set (called #1 after a rising edge), accept on the next
    // edge, queue the expected result, then scramble the inputs.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] full;
        exp_t       e;
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        chk("in_ready_before_accept", W'(in_ready), W'(1'b1));
        full   = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        cin      = ~cv;
    endtask

    // Wait (bounded) for out_valid; returns cycles since the accept edge.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=out_valid 0 expected=out_valid 1", tag);
        end
    endtask

    // Compare the presented result against the scoreboard head.
    task automatic cmp_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_empty observed=result expected=none", tag);
        end else begin
            e = sb[0];
            chk({tag, "_sum"},  sum, e.sum);
            chk({tag, "_cout"}, W'(cout), W'(e.cout));
`ifdef MPADD_OVF_EN
            chk({tag, "_ovf"},  W'(ovf), W'(e.ovf));
`endif
        end
    endtask

    // Full transaction with out_ready high: latency, data, handshake return.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv);
        int lat;
        send(av, bv, cv);
        wait_valid(tag, lat);
        chk({tag, "_latency"}, W'(lat), W'(WORDS));
        cmp_head(tag);
        @(posedge clk);
        #1;
        if (sb.size() > 0) void'(sb.pop_front());
        chk({tag, "_valid_drop"}, W'(out_valid), W'(1'b0));
        chk({tag, "_ready_back"}, W'(in_ready), W'(1'b1));
    endtask

    initial begin
        int   lat;
        logic ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = {W{1'b0}};
        b         = {W{1'b0}};
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  W'(in_ready),  W'(1'b1));
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_sum",       sum,           {W{1'b0}});
        chk("rst_cout",      W'(cout),      W'(1'b0));
`ifdef MPADD_OVF_EN
        chk("rst_ovf",       W'(ovf),       W'(1'b0));
`endif
        rst = 1'b0;

        // First accept right after reset release
        run_op("carry_chunk0", 64'h0000_0000_0000_1A33, 64'h0000_0000_0000_E5EB, 1'b0);
        run_op("wrap_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1);
        run_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
        run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        run_op("chain_mid", 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("random", {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Back-pressure: result held while in_valid offers new operands
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        wait_valid("hold", lat);
        chk("hold_latency", W'(lat), W'(WORDS));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            cin      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== sb[0].sum || cout !== sb[0].cout)
                ok = 1'b0;
        end
        chk("hold_stable_10cyc", W'(ok), W'(1'b1));
        cmp_head("hold_end");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (sb.size() > 0) void'(sb.pop_front());
        chk("hold_release_valid", W'(out_valid), W'(1'b0));
        chk("hold_release_ready", W'(in_ready),  W'(1'b1));
        ok = 1'b1;
        for (int i = 0; i < WORDS + 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        chk("hold_no_second_capture", W'(ok), W'(1'b1));

        // Reset while the adder is on chunk 2 aborts the operation
        send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid_in_rst", W'(out_valid), W'(1'b0));
        chk("abort_ready_in_rst", W'(in_ready),  W'(1'b1));
        chk("abort_sum_in_rst",   sum,           {W{1'b0}});
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        ok = 1'b1;
        for (int i = 0; i < WORDS + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_out_valid", W'(ok), W'(1'b1));
        run_op("after_abort", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0);

        chk("scoreboard_drained", W'(sb.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
